// File: rtl/nand_arb_pkg.sv
// Shared types for the NAND command-channel arbiter,
// the memory controller and their benches.
package nand_arb_pkg;

  typedef enum logic [1:0] {
    READ    = 2'b00,
    PROGRAM = 2'b01,
    ERASE   = 2'b10,
    RSVD    = 2'b11
  } nand_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    COMPLETE
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or
// after ptr wins; grant is one-hot.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;
  logic [IW-1:0] k;

  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    k   = '0;
    // Scan from the farthest offset so the closest one wins.
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      k = IW'(j);
      if (req[k]) begin
        idx = k;
        any = 1'b1;
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/nand_cmd_arbiter.sv
// Round-robin sharing of the NAND controller command
// channel with per-requester done/error reporting.
module nand_cmd_arbiter
  import nand_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*2-1:0]        req_op,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [NUM_REQ-1:0]          req_err,
  input  logic                        mc_busy,
  output logic                        mc_start,
  output logic [1:0]                  mc_op,
  output logic [ADDR_W-1:0]           mc_addr,
  input  logic                        mc_done,
  input  logic                        mc_fail
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

  arb_state_e state, state_n;
  logic [IW-1:0] rr_ptr, rr_ptr_n;
  logic [IW-1:0] gidx, gidx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] ready_n, done_n, err_n;
  logic [NUM_REQ-1:0] gnt, sel;
  logic [IW-1:0] pick;
  logic any, start_n;
  logic [1:0] op_n;
  logic [ADDR_W-1:0] addr_n;

  logic [1:0]        ops   [NUM_REQ];
  logic [ADDR_W-1:0] addrs [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign ops[i]   = req_op[i*2 +: 2];
    assign addrs[i] = req_addr[i*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (pick),
    .any (any)
  );

  assign sel = NUM_REQ'(1) << gidx;

  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    gidx_n   = gidx;
    cnt_n    = cnt;
    ready_n  = '0;
    done_n   = '0;
    err_n    = '0;
    start_n  = 1'b0;
    op_n     = mc_op;
    addr_n   = mc_addr;
    unique case (state)
      IDLE: begin
        if (any && !mc_busy) begin
          gidx_n  = pick;
          op_n    = ops[pick];
          addr_n  = addrs[pick];
          ready_n = gnt;
          start_n = (ops[pick] != RSVD);
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n = '0;
        if (mc_op == RSVD) begin
          done_n  = sel;
          err_n   = sel;
          state_n = COMPLETE;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '1) cnt_n = cnt + 1'b1;
        // Completion wins over a timeout in the same cycle.
        if (mc_done) begin
          done_n  = sel;
          err_n   = mc_fail ? sel : '0;
          state_n = COMPLETE;
        end else if (cnt >= TO_LAST) begin
          done_n  = sel;
          err_n   = sel;
          state_n = COMPLETE;
        end
      end
      COMPLETE: begin
        rr_ptr_n = (gidx == LAST) ? '0 : gidx + 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      cnt       <= '0;
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= '0;
      mc_start  <= 1'b0;
      mc_op     <= '0;
      mc_addr   <= '0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_ptr_n;
      gidx      <= gidx_n;
      cnt       <= cnt_n;
      req_ready <= ready_n;
      req_done  <= done_n;
      req_err   <= err_n;
      mc_start  <= start_n;
      mc_op     <= op_n;
      mc_addr   <= addr_n;
    end
  end

endmodule

// File: tb/tb_nand_cmd_arbiter.sv
// Directed bench for nand_cmd_arbiter: grant order, latency,
// busy stall, timeout, illegal op and mid-op reset.
module tb_nand_cmd_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N*2-1:0]  req_op;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready, req_done, req_err;
  logic          mc_busy, mc_start, mc_done, mc_fail;
  logic [1:0]    mc_op;
  logic [AW-1:0] mc_addr;

  logic [1:0]    op_a   [N];
  logic [AW-1:0] addr_a [N];

  int n_chk = 0;
  int n_err = 0;
  logic saw;

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_op[i*2 +: 2]    = op_a[i];
    assign req_addr[i*AW +: AW] = addr_a[i];
  end

  nand_cmd_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .req_done  (req_done),
    .req_err   (req_err),
    .mc_busy   (mc_busy),
    .mc_start  (mc_start),
    .mc_op     (mc_op),
    .mc_addr   (mc_addr),
    .mc_done   (mc_done),
    .mc_fail   (mc_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " ready"}, 32'(req_ready), 0);
    chk({tag, " done"},  32'(req_done),  0);
    chk({tag, " err"},   32'(req_err),   0);
    chk({tag, " start"}, 32'(mc_start),  0);
    chk({tag, " op"},    32'(mc_op),     0);
    chk({tag, " addr"},  32'(mc_addr),   0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    mc_busy = 1'b0;
    mc_done = 1'b0;
    mc_fail = 1'b0;
    for (int i = 0; i < N; i++) begin
      op_a[i]   = 2'b00;
      addr_a[i] = 16'h0;
    end
    step();
    step();
    chk_quiet("rst");
    rst_n = 1'b1;

    // single read from requester 1
    addr_a[1] = 16'h0123;
    req_valid = 4'b0010;
    step();
    chk("t1 ready", 32'(req_ready), 32'h2);
    chk("t1 start", 32'(mc_start), 1);
    chk("t1 op",    32'(mc_op), 0);
    chk("t1 addr",  32'(mc_addr), 32'h0123);
    req_valid = '0;
    step();
    chk("t1 start1", 32'(mc_start), 0);
    chk("t1 ready1", 32'(req_ready), 0);
    step(); step(); step(); step();
    chk("t1 hold addr", 32'(mc_addr), 32'h0123);
    mc_done = 1'b1;
    step();
    mc_done = 1'b0;
    chk("t1 done", 32'(req_done), 32'h2);
    chk("t1 err",  32'(req_err), 0);
    step();
    chk("t1 done1", 32'(req_done), 0);

    // reset then all four requesting, immediate completion
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) addr_a[i] = 16'h1000 + 16'(i);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rr%0d ready", n), 32'(req_ready),
          32'(1) << (n % 4));
      chk($sformatf("rr%0d addr", n), 32'(mc_addr),
          32'h1000 + 32'(n % 4));
      step();
      mc_done = 1'b1;
      step();
      mc_done = 1'b0;
      chk($sformatf("rr%0d done", n), 32'(req_done),
          32'(1) << (n % 4));
      step();
    end
    req_valid = '0;

    // busy stall, ptr now 1; requester 3 program
    op_a[3]   = 2'b01;
    addr_a[3] = 16'h5A5A;
    mc_busy   = 1'b1;
    req_valid = 4'b1000;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      saw = saw | mc_start | (|req_ready);
    end
    chk("busy nostart", 32'(saw), 0);
    mc_busy = 1'b0;
    step();
    chk("busy start", 32'(mc_start), 1);
    chk("busy ready", 32'(req_ready), 32'h8);
    chk("busy op",    32'(mc_op), 1);
    req_valid = '0;
    // done coincident with start must be ignored
    mc_done = 1'b1;
    mc_fail = 1'b1;
    step();
    mc_done = 1'b0;
    step();
    chk("early done ign", 32'(req_done), 0);
    mc_done = 1'b1;
    step();
    mc_done = 1'b0;
    mc_fail = 1'b0;
    chk("fail done", 32'(req_done), 32'h8);
    chk("fail err",  32'(req_err),  32'h8);
    step();

    // timeout, ptr now 0; requester 0 erase
    op_a[0]   = 2'b10;
    addr_a[0] = 16'hBEEF;
    req_valid = 4'b0001;
    step();
    chk("to ready", 32'(req_ready), 32'h1);
    chk("to op",    32'(mc_op), 2);
    req_valid = '0;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("to early", 32'(req_done), 0);
    step();
    chk("to done", 32'(req_done), 32'h1);
    chk("to err",  32'(req_err),  32'h1);
    mc_done = 1'b1;
    step();
    chk("late done1", 32'(req_done), 0);
    step();
    mc_done = 1'b0;
    chk("late done2", 32'(req_done), 0);
    chk("late ready", 32'(req_ready), 0);

    // reserved op from requester 2, ptr now 1
    op_a[2] = 2'b11;
    req_valid = 4'b0100;
    step();
    chk("rsvd ready", 32'(req_ready), 32'h4);
    chk("rsvd start", 32'(mc_start), 0);
    req_valid = '0;
    step();
    chk("rsvd done", 32'(req_done), 32'h4);
    chk("rsvd err",  32'(req_err),  32'h4);
    step();

    // reset during WAIT, ptr now 3
    op_a[1] = 2'b00;
    req_valid = 4'b0110;
    step();
    chk("mid ready", 32'(req_ready), 32'h2);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk_quiet("mid rst");
    rst_n = 1'b1;
    op_a[0] = 2'b00;
    op_a[3] = 2'b00;
    req_valid = 4'b1001;
    step();
    chk("post ready", 32'(req_ready), 32'h1);
    chk("post addr",  32'(mc_addr), 32'hBEEF);
    chk("post done",  32'(req_done), 0);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
